// File: rtl/pipeline_exec_ctrl.sv
// Execution and hazard controller for the 5-stage MIPS pipeline: sequences clk_en
// for run / single-step / halt-drain and drives IF/ID stall, flush and PC write.
//
// state  | meaning
// IDLE   | paused, clk_en low, waiting for a debug command
// RUN    | continuous execution until stop or HALT opcode in ID
// STEP   | exactly one enabled pipeline cycle
// DRAIN  | HALT seen in ID; bubbles injected while EX/MEM/WB retire
// HALTED | program finished and drained; only reset leaves
module pipeline_exec_ctrl #(
    parameter int          DRAIN_CYCLES = 4,
    parameter int          CNT_W        = 32,
    parameter logic [5:0]  HALT_OPCODE  = 6'b111111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_run,
    input  logic             cmd_step,
    input  logic             cmd_stop,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             id_branch_taken,
    output logic             clk_en,
    output logic             pc_write,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             halted,
    output logic             busy,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_STEP   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    localparam int             DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] drain_cnt, drain_d;
    logic          halt_det;
    logic          load_use;

    assign halt_det = ((state_q == S_RUN) || (state_q == S_STEP)) && (id_opcode == HALT_OPCODE);
    assign load_use = ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    always_comb begin
        state_d = state_q;
        drain_d = drain_cnt;
        case (state_q)
            S_IDLE: begin
                if (cmd_stop)      state_d = S_IDLE;
                else if (cmd_run)  state_d = S_RUN;
                else if (cmd_step) state_d = S_STEP;
            end
            S_RUN: begin
                if (halt_det) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (cmd_stop) begin
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                if (halt_det) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) state_d = S_HALTED;
                else                 drain_d = drain_cnt - 1'b1;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            drain_cnt   <= '0;
            cycle_count <= '0;
        end else begin
            state_q   <= state_d;
            drain_cnt <= drain_d;
            // Saturate rather than wrap so long runs never read back as short ones
            if (clk_en && (cycle_count != '1))
                cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    always_comb begin
        clk_en      = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
        pc_write    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        if (clk_en) begin
            if ((state_q == S_DRAIN) || halt_det) begin
                if_id_flush = 1'b1;
            end else if (load_use) begin
                // Stall beats a taken branch; the branch re-resolves next cycle
                if_id_stall = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_flush = id_branch_taken;
            end
        end
    end

    assign halted = (state_q == S_HALTED);
    assign busy   = clk_en;
    assign state  = state_q;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Scoreboard bench for pipeline_exec_ctrl: a behavioural model pushes the expected
// outputs for each driven cycle and every test task pops and compares them.
module tb_pipeline_exec_ctrl;

    localparam int CW    = 4;
    localparam int DRAIN = 4;

    typedef struct packed {
        logic          ce, pc, stall, flush, halted, busy;
        logic [2:0]    st;
        logic [CW-1:0] cnt;
    } obs_t;

    typedef struct packed {
        logic       run, step, stop;
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic       mr;
        logic [4:0] ert;
        logic       br;
    } stim_t;

    logic          clk = 0, reset = 1;
    logic          cmd_run = 0, cmd_step = 0, cmd_stop = 0;
    logic [5:0]    id_opcode = 0;
    logic [4:0]    id_rs = 0, id_rt = 0, ex_rt = 0;
    logic          ex_mem_read = 0, id_branch_taken = 0;
    logic          clk_en, pc_write, if_id_stall, if_id_flush, halted, busy;
    logic [2:0]    state;
    logic [CW-1:0] cycle_count;

    obs_t obs;
    obs_t sb[$];
    int   n_chk = 0, n_fail = 0;

    logic [2:0]    m_state = 0, n_state = 0;
    int            m_drain = 0, n_drain = 0;
    logic [CW-1:0] m_cnt = 0, n_cnt = 0;

    pipeline_exec_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW), .HALT_OPCODE(6'b111111)) dut (
        .clk(clk), .reset(reset),
        .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_stop(cmd_stop),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_branch_taken(id_branch_taken),
        .clk_en(clk_en), .pc_write(pc_write), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .halted(halted), .busy(busy),
        .state(state), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    assign obs = '{ce: clk_en, pc: pc_write, stall: if_id_stall, flush: if_id_flush,
                   halted: halted, busy: busy, st: state, cnt: cycle_count};

    function automatic stim_t cmd(input logic r, input logic s, input logic p);
        stim_t x = '0;
        x.run = r; x.step = s; x.stop = p;
        return x;
    endfunction

    function automatic stim_t haz(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic mr, input logic [4:0] ert, input logic br);
        stim_t x = '0;
        x.op = op; x.rs = rs; x.rt = rt; x.mr = mr; x.ert = ert; x.br = br;
        return x;
    endfunction

    // Drive one cycle of stimulus, push the expected outputs and precompute the model's next state
    task automatic drive(input stim_t s);
        obs_t e;
        logic hd, lu;
        cmd_run = s.run; cmd_step = s.step; cmd_stop = s.stop;
        id_opcode = s.op; id_rs = s.rs; id_rt = s.rt;
        ex_mem_read = s.mr; ex_rt = s.ert; id_branch_taken = s.br;
        hd = (m_state == 3'd1 || m_state == 3'd2) && (s.op == 6'h3F);
        lu = s.mr && (s.ert != 0) && (s.ert == s.rs || s.ert == s.rt);
        e = '0;
        e.st = m_state; e.cnt = m_cnt;
        e.halted = (m_state == 3'd4);
        e.busy = (m_state == 3'd1 || m_state == 3'd2 || m_state == 3'd3);
        e.ce = e.busy;
        if (e.ce) begin
            if (m_state == 3'd3 || hd) e.flush = 1;
            else if (lu) e.stall = 1;
            else begin e.pc = 1; e.flush = s.br; end
        end
        sb.push_back(e);
        n_state = m_state; n_drain = m_drain;
        case (m_state)
            3'd0: if (s.stop) n_state = 0; else if (s.run) n_state = 1; else if (s.step) n_state = 2;
            3'd1: if (hd) begin n_state = 3; n_drain = DRAIN - 1; end else if (s.stop) n_state = 0;
            3'd2: if (hd) begin n_state = 3; n_drain = DRAIN - 1; end else n_state = 0;
            3'd3: if (m_drain == 0) n_state = 4; else n_drain = m_drain - 1;
            default: ;
        endcase
        n_cnt = (e.ce && m_cnt != '1) ? m_cnt + 1'b1 : m_cnt;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin m_state = n_state; m_drain = n_drain; m_cnt = n_cnt; end
        #1;
        cmd_run = 0; cmd_step = 0; cmd_stop = 0;
    endtask

    task automatic apply_reset();
        reset = 1; m_state = 0; m_drain = 0; m_cnt = 0;
        cmd_run = 1; cmd_step = 1;
        @(posedge clk); #1;
        cmd_run = 0; cmd_step = 0;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_reset();
        obs_t e;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            drive('0);
            @(negedge clk);
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL reset[%0d]: got %h expected %h", i, obs, e); end
            tick();
        end
    endtask

    task automatic test_step();
        stim_t q[$];
        obs_t  e;
        apply_reset();
        q = '{cmd(0,1,0), '0, '0, '0};
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL step[%0d]: got %h expected %h", i, obs, e); end
            tick();
        end
    endtask

    task automatic test_run_stop();
        stim_t q[$];
        obs_t  e;
        apply_reset();
        q.push_back(cmd(1,0,0));
        for (int i = 0; i < 9; i++) q.push_back(cmd(i == 3, i == 5, 0));
        q.push_back(cmd(0,0,1));
        q.push_back('0);
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL run_stop[%0d]: got %h expected %h", i, obs, e); end
            tick();
        end
    endtask

    task automatic test_load_use();
        stim_t q[$];
        obs_t  e;
        apply_reset();
        q = '{cmd(1,0,0),
              haz(6'h23, 5, 0, 1, 5, 0),
              haz(6'h23, 5, 0, 1, 5, 1),
              haz(6'h00, 0, 0, 1, 0, 0),
              haz(6'h00, 3, 7, 1, 7, 1),
              haz(6'h00, 5, 5, 0, 5, 0),
              haz(6'h04, 1, 2, 0, 0, 1),
              haz(6'h04, 5, 6, 1, 9, 1),
              cmd(0,0,1), '0};
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL load_use[%0d]: got %h expected %h", i, obs, e); end
            tick();
        end
    endtask

    task automatic test_halt_drain();
        stim_t q[$];
        stim_t s;
        obs_t  e;
        apply_reset();
        q = '{cmd(1,0,0), '0, haz(6'h3F, 1, 2, 1, 1, 1)};
        for (int i = 0; i < DRAIN; i++) begin
            s = haz(6'h3F, 4, 4, 1, 4, 1);
            s.stop = (i == 1); s.step = (i == 2);
            q.push_back(s);
        end
        q.push_back(cmd(1,0,0));
        q.push_back(cmd(0,1,0));
        q.push_back(cmd(1,0,0));
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL halt_drain[%0d]: got %h expected %h", i, obs, e); end
            tick();
        end
    endtask

    task automatic test_cmd_priority();
        stim_t q[$];
        stim_t s;
        obs_t  e;
        apply_reset();
        s = haz(6'h3F, 0, 0, 0, 0, 0); s.stop = 1;
        q = '{cmd(1,0,1), cmd(1,1,1), cmd(0,1,0), haz(6'h3F, 0, 0, 0, 0, 0), '0,
              '0, '0, '0, '0};
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL cmd_prio[%0d]: got %h expected %h", i, obs, e); end
            tick();
        end
        apply_reset();
        q = '{cmd(1,1,0), '0, s, '0, '0};
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL stop_vs_halt[%0d]: got %h expected %h", i, obs, e); end
            tick();
        end
    endtask

    task automatic test_reset_mid_drain();
        stim_t q[$];
        obs_t  e;
        apply_reset();
        q = '{cmd(1,0,0), '0, haz(6'h3F, 0, 0, 0, 0, 0), '0};
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL pre_reset[%0d]: got %h expected %h", i, obs, e); end
            tick();
        end
        // Now in the second DRAIN cycle; hit reset asynchronously between edges
        #2;
        reset = 1; m_state = 0; m_drain = 0; m_cnt = 0;
        drive(cmd(1,0,0));
        @(negedge clk);
        e = sb.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL mid_drain_reset: got %h expected %h", obs, e); end
        tick();
        reset = 0;
        q = '{cmd(1,0,0), '0, haz(6'h23, 8, 0, 1, 8, 0), '0, cmd(0,0,1), '0};
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL post_reset[%0d]: got %h expected %h", i, obs, e); end
            tick();
        end
    endtask

    task automatic test_saturation();
        stim_t q[$];
        obs_t  e;
        apply_reset();
        q.push_back(cmd(1,0,0));
        for (int i = 0; i < 20; i++) q.push_back('0);
        q.push_back(cmd(0,0,1));
        q.push_back('0);
        foreach (q[i]) begin
            drive(q[i]);
            @(negedge clk);
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL saturation[%0d]: got %h expected %h", i, obs, e); end
            tick();
        end
        n_chk++;
        if (cycle_count !== {CW{1'b1}}) begin
            n_fail++;
            $display("FAIL sat_final: got %0d expected %0d", cycle_count, {CW{1'b1}});
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_run_stop();
        test_load_use();
        test_halt_drain();
        test_cmd_priority();
        test_reset_mid_drain();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_exec_ctrl.md
Name: pipeline_exec_ctrl

Overview:
Execution and hazard controller for the 5-stage MIPS pipeline. It sequences the global clk_en used by the debug unit in run, single-step and halt-drain modes. It also generates the IF/ID stall/flush and PC write-enable from load-use and branch hazards. It sits between the debug command interface and the IF stage / IF_ID segment register.

Parameters:
DRAIN_CYCLES, 4, number of clk_en cycles after a HALT is detected in ID before entering HALTED; covers the EX/MEM/WB drain plus one margin cycle; must be ≥1.
CNT_W, 32, width of the executed-cycle counter.
HALT_OPCODE, 6'b111111, opcode that marks end of program.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cmd_run  input  1  single-cycle pulse: start continuous execution
cmd_step  input  1  single-cycle pulse: execute exactly one pipeline cycle
cmd_stop  input  1  single-cycle pulse: pause continuous execution
id_opcode  input  6  opcode currently held in IF/ID
id_rs  input  5  rs field currently held in IF/ID
id_rt  input  5  rt field currently held in IF/ID
ex_mem_read  input  1  instruction in ID/EX is a load
ex_rt  input  5  destination rt of the instruction in ID/EX
id_branch_taken  input  1  branch resolved taken in ID
clk_en  output  1  pipeline clock enable
pc_write  output  1  PC update enable
if_id_stall  output  1  hold IF/ID
if_id_flush  output  1  clear IF/ID
halted  output  1  program finished, pipeline drained
busy  output  1  state is RUN, STEP or DRAIN
state  output  3  current FSM state
cycle_count  output  CNT_W  number of cycles with clk_en=1

Behaviour:
- States (encoding): IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4. The state register and all counters are asynchronously reset to IDLE / 0.
- After reset, every output is 0.
- Outputs are combinational from state and inputs; there is no output latency.
- clk_en = 1 in RUN, STEP and DRAIN; 0 in IDLE and HALTED.
- Command priority when several are asserted in the same cycle: stop > run > step.
- IDLE:
  - cmd_stop: stay in IDLE.
  - cmd_run: go to RUN.
  - cmd_step: go to STEP.
- RUN:
  - halt_det (defined below): go to DRAIN and load drain_cnt = DRAIN_CYCLES-1.
  - Otherwise cmd_stop: go to IDLE.
  - halt_det has priority over cmd_stop.
  - cmd_run and cmd_step are ignored.
- STEP:
  - Lasts exactly one cycle.
  - halt_det: go to DRAIN.
  - Otherwise: go to IDLE.
  - All commands are ignored.
- DRAIN:
  - All commands are ignored.
  - drain_cnt decrements each cycle; at drain_cnt==0, go to HALTED.
  - DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
- HALTED: sticky; only reset exits.
- halt_det = (state==RUN or STEP) and id_opcode==HALT_OPCODE.
- load_use = ex_mem_read and ex_rt!=0 and (ex_rt==id_rs or ex_rt==id_rt).
- Hazard outputs while clk_en=0: pc_write=0, if_id_stall=0, if_id_flush=0.
- Hazard outputs while clk_en=1, in priority order:
  1. DRAIN or halt_det: pc_write=0, if_id_flush=1, if_id_stall=0. No instruction after HALT enters ID; bubbles are injected.
  2. load_use: pc_write=0, if_id_stall=1, if_id_flush=0. Stall wins over a branch flush; the branch re-resolves on the next cycle.
  3. id_branch_taken: pc_write=1, if_id_flush=1.
  4. Otherwise: pc_write=1, stall=0, flush=0.
- if_id_stall and if_id_flush are never asserted together.
- cycle_count increments on every posedge where clk_en=1 and saturates at all-ones; it does not wrap.
- halted = (state==HALTED). busy = RUN|STEP|DRAIN.
- Reset asserted mid-RUN or mid-DRAIN: immediate return to IDLE with counters cleared. Commands pulsed during reset are lost.

Test Plan:
- Reset, then cmd_step pulse → state 0→2→0; clk_en high exactly 1 cycle; pc_write=1; cycle_count=1.
- cmd_run, no hazards, cmd_stop after 10 cycles → clk_en high 10 cycles; cycle_count=10; state=IDLE; busy=0.
- RUN with ex_mem_read=1, ex_rt=5, id_rs=5 → if_id_stall=1, pc_write=0.
  - Same case with id_branch_taken=1 → still stall only, flush=0.
  - ex_rt=0 → no stall.
- RUN with id_opcode=6'h3F → flush=1, pc_write=0 that cycle.
  - Then 4 DRAIN cycles with flush=1 and clk_en=1.
  - Then HALTED: halted=1, clk_en=0; cmd_run ignored.
- cmd_run and cmd_stop in the same cycle from IDLE → stays IDLE.
  - cmd_stop together with halt_det in RUN → DRAIN.
- Reset asserted in the 2nd DRAIN cycle → all outputs 0, state=IDLE; a subsequent cmd_run runs normally.
